fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 112 +++++++++++
 tb/tb_fetch_stage.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one word-aligned request at a time and buffers
// the tagged responses in a small prefetch FIFO that feeds decode.
module fetch_stage #(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  localparam int              AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int              CW      = AW + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [31:0]     NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    DISCARD
  } state_t;

  state_t          state_q, state_d;
  logic [29:0]     fpc_p0;
  logic [29:0]     tag_pc_p0;
  logic [29:0]     buf_pc_p1  [FIFO_DEPTH];
  logic [31:0]     buf_ins_p1 [FIFO_DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic            grant, push, pop, vld_p1;
  logic            unused_target_lsbs;

  assign unused_target_lsbs = ^jump_target_i[1:0];

  // Request stage: a request is only allowed from FETCH, where nothing is
  // outstanding, so the FIFO occupancy alone decides whether a slot is reserved.
  always_comb begin
    instr_req_o = (state_q == FETCH) && (count < DEPTH_C) && !jump_i && !rst_i;
    grant       = instr_req_o && instr_gnt_i;
    push        = (state_q == WAIT) && instr_rvalid_i && !jump_i;
    vld_p1      = (count != '0);
    pop         = vld_p1 && instr_ready_i && !jump_i;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:   if (grant) state_d = WAIT;
      WAIT: begin
        if (instr_rvalid_i)  state_d = FETCH;
        else if (jump_i)     state_d = DISCARD;
      end
      DISCARD: if (instr_rvalid_i) state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FETCH;
      fpc_p0  <= BOOT_ADDR[31:2];
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
    end else begin
      state_q <= state_d;
      if (jump_i)      fpc_p0 <= jump_target_i[31:2];
      else if (grant)  fpc_p0 <= fpc_p0 + 30'd1;
      if (jump_i) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        unique case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Response stage: tag captured at grant, entry written when the data returns.
  always_ff @(posedge clk_i) begin
    if (grant) tag_pc_p0 <= fpc_p0;
    if (push) begin
      buf_pc_p1[wr_ptr]  <= tag_pc_p0;
      buf_ins_p1[wr_ptr] <= instr_rdata_i;
    end
  end

  // Output stage: FIFO head, or a NOP at pc 0 when nothing is buffered.
  always_comb begin
    instr_addr_o  = {fpc_p0, 2'b00};
    instr_valid_o = vld_p1;
    instr_o       = vld_p1 ? buf_ins_p1[rd_ptr] : NOP;
    pc_o          = vld_p1 ? {buf_pc_p1[rd_ptr], 2'b00} : 32'h0;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: queue-based reference model checked every cycle, plus
// directed scenarios with hand-computed address/pc sequences.
module tb_fetch_stage;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i = 1'b0;
  logic        instr_rvalid_i = 1'b0;
  logic [31:0] instr_rdata_i = 32'h0;
  logic        jump_i = 1'b0;
  logic [31:0] jump_target_i = 32'h0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instr_o;
  logic [31:0] pc_o;

  fetch_stage #(.BOOT_ADDR(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o),
    .instr_gnt_i(instr_gnt_i), .instr_rvalid_i(instr_rvalid_i),
    .instr_rdata_i(instr_rdata_i), .jump_i(jump_i), .jump_target_i(jump_target_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_o(instr_o), .pc_o(pc_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0003;
  endfunction

  // Reference model: queue of buffered {pc, instr}, next fetch address,
  // one pending-response flag and a flag marking that response as stale.
  typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_npc = 32'h0;
  logic [31:0] m_tag = 32'h0;
  bit          m_pend = 1'b0;
  bit          m_disc = 1'b0;
  bit          model_ok = 1'b0;
  logic        exp_req;

  logic [31:0] req_log[$];
  logic [31:0] pop_log[$];
  int          cyc = 0;
  int          t0 = 0;
  int          fv = -1;
  bit          mark_t0 = 1'b0;
  bit          want_fv = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (mark_t0) begin t0 = cyc; mark_t0 = 1'b0; end
    if (want_fv && instr_valid_o) begin fv = cyc; want_fv = 1'b0; end
    exp_req = !rst_i && !m_pend && (mq.size() < DEPTH) && !jump_i;
    if (model_ok) begin
      chk("req",   32'(instr_req_o), 32'(exp_req));
      chk("addr",  instr_addr_o, m_npc);
      chk("valid", 32'(instr_valid_o), 32'(mq.size() != 0));
      chk("instr", instr_o, (mq.size() != 0) ? mq[0].ins : 32'h0000_0013);
      chk("pc",    pc_o,    (mq.size() != 0) ? mq[0].pc  : 32'h0);
      if (!rst_i) begin
        if (instr_req_o && instr_gnt_i) req_log.push_back(instr_addr_o);
        if (instr_valid_o && instr_ready_i && !jump_i) pop_log.push_back(pc_o);
      end
    end
    if (rst_i) begin
      mq.delete();
      m_npc = 32'h0;
      m_pend = 1'b0;
      m_disc = 1'b0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      if (jump_i) begin
        mq.delete();
        if (m_pend) begin
          if (instr_rvalid_i) begin m_pend = 1'b0; m_disc = 1'b0; end
          else m_disc = 1'b1;
        end
        m_npc = {jump_target_i[31:2], 2'b00};
      end else begin
        if (mq.size() != 0 && instr_ready_i) void'(mq.pop_front());
        if (m_pend && instr_rvalid_i) begin
          if (!m_disc) mq.push_back('{m_tag, instr_rdata_i});
          m_pend = 1'b0;
          m_disc = 1'b0;
        end
        if (exp_req && instr_gnt_i) begin
          m_tag  = m_npc;
          m_npc  = m_npc + 32'd4;
          m_pend = 1'b1;
        end
      end
    end
  end

  // Memory responder driven from the stimulus thread: rvalid follows a grant
  // after resp_lat cycles.
  int          resp_lat = 1;
  bit          pend_act = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = 32'h0;

  task automatic tick();
    @(negedge clk);
    if (instr_req_o && instr_gnt_i) begin
      pend_addr = instr_addr_o;
      pend_cnt  = resp_lat;
      pend_act  = 1'b1;
    end
    @(posedge clk);
    #1;
    instr_rvalid_i = 1'b0;
    if (pend_act) begin
      if (pend_cnt <= 1) begin
        instr_rvalid_i = 1'b1;
        instr_rdata_i  = mem_word(pend_addr);
        pend_act       = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
  endtask

  task automatic do_reset(input int n);
    pend_act = 1'b0;
    rst_i = 1'b1;
    repeat (n) tick();
    chk("rst_valid", 32'(instr_valid_o), 32'h0);
    chk("rst_instr", instr_o, 32'h0000_0013);
    chk("rst_pc",    pc_o, 32'h0);
    chk("rst_req",   32'(instr_req_o), 32'h0);
    chk("rst_addr",  instr_addr_o, 32'h0);
    rst_i = 1'b0;
    req_log.delete();
    pop_log.delete();
  endtask

  initial begin
    // Straight-line fetch with an always-granting memory.
    instr_gnt_i = 1'b1; instr_ready_i = 1'b1; resp_lat = 1;
    do_reset(2);
    mark_t0 = 1'b1; want_fv = 1'b1;
    repeat (10) tick();
    chk("s1_req0", req_log[0], 32'h0);
    chk("s1_req1", req_log[1], 32'h4);
    chk("s1_req2", req_log[2], 32'h8);
    chk("s1_pc0",  pop_log[0], 32'h0);
    chk("s1_pc1",  pop_log[1], 32'h4);
    chk("s1_pc2",  pop_log[2], 32'h8);
    chk("s1_first_valid_lat", 32'(fv - t0), 32'd2);

    // Decode stalled: exactly DEPTH fetches, then drain in order.
    instr_gnt_i = 1'b1; instr_ready_i = 1'b0; resp_lat = 1;
    do_reset(2);
    repeat (10) tick();
    chk("s2_nreq",  32'(req_log.size()), 32'd2);
    chk("s2_req",   32'(instr_req_o), 32'h0);
    chk("s2_pc",    pc_o, 32'h0);
    chk("s2_instr", instr_o, mem_word(32'h0));
    instr_ready_i = 1'b1;
    repeat (8) tick();
    chk("s2_pop0", pop_log[0], 32'h0);
    chk("s2_pop1", pop_log[1], 32'h4);
    chk("s2_req2", req_log[2], 32'h8);

    // Jump while a request is outstanding: stale response is discarded.
    instr_gnt_i = 1'b1; instr_ready_i = 1'b1; resp_lat = 3;
    do_reset(2);
    tick();
    jump_i = 1'b1; jump_target_i = 32'h0000_0103;
    tick();
    jump_i = 1'b0;
    repeat (10) tick();
    chk("s3_req0", req_log[0], 32'h0);
    chk("s3_req1", req_log[1], 32'h100);
    chk("s3_pop0", pop_log[0], 32'h100);

    // Jump coincident with rvalid and ready: no pop, data dropped.
    instr_gnt_i = 1'b1; instr_ready_i = 1'b0; resp_lat = 1;
    do_reset(2);
    repeat (3) tick();
    jump_i = 1'b1; jump_target_i = 32'h0000_0200; instr_ready_i = 1'b1;
    tick();
    jump_i = 1'b0;
    repeat (8) tick();
    chk("s4_pop0", pop_log[0], 32'h200);
    chk("s4_req2", req_log[2], 32'h200);

    // Grant withheld, then address wrap from the top of memory.
    instr_gnt_i = 1'b0; instr_ready_i = 1'b1; resp_lat = 1;
    do_reset(2);
    jump_i = 1'b1; jump_target_i = 32'hFFFF_FFFC;
    tick();
    jump_i = 1'b0;
    repeat (5) tick();
    chk("s5_req_held",  32'(instr_req_o), 32'h1);
    chk("s5_addr_held", instr_addr_o, 32'hFFFF_FFFC);
    chk("s5_nreq",      32'(req_log.size()), 32'd0);
    instr_gnt_i = 1'b1;
    repeat (8) tick();
    chk("s5_req0", req_log[0], 32'hFFFF_FFFC);
    chk("s5_req1", req_log[1], 32'h0);
    chk("s5_pop0", pop_log[0], 32'hFFFF_FFFC);
    chk("s5_pop1", pop_log[1], 32'h0);

    // Reset while waiting; the late response must be ignored.
    instr_gnt_i = 1'b1; instr_ready_i = 1'b1; resp_lat = 4;
    do_reset(2);
    tick();
    instr_gnt_i = 1'b0;
    rst_i = 1'b1;
    repeat (2) tick();
    rst_i = 1'b0;
    req_log.delete();
    pop_log.delete();
    repeat (2) tick();
    chk("s6_valid_after_stale", 32'(instr_valid_o), 32'h0);
    instr_gnt_i = 1'b1; resp_lat = 1;
    repeat (8) tick();
    chk("s6_req0", req_log[0], 32'h0);
    chk("s6_pop0", pop_log[0], 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
